byte_uart_tx: RTL and testbench

Byte-stream UART transmitter fed by the byte serializer stage. It accepts one byte per strobe into a small FIFO and sends each byte as an 8N1 frame: one start bit, eight data bits LSB first, one stop bit. It throttles the serializer through `can_accept`, which leaves one entry of slack for the byte already in flight.

---
 rtl/byte_uart_tx_if.sv | 14 +
 rtl/byte_uart_tx.sv | 98 +++++++++
 tb/tb_byte_uart_tx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/byte_uart_tx_if.sv
// byte_uart_tx_if: serializer-side byte strobe and UART status bundle
interface byte_uart_tx_if #(
  parameter int FIFO_AW = 4
);
  logic [7:0] din;
  logic din_valid;
  logic can_accept;
  logic tx;
  logic busy;
  logic overflow;
  logic [FIFO_AW:0] level;
  modport master (output din, din_valid, input can_accept, tx, busy, overflow, level);
  modport slave (input din, din_valid, output can_accept, tx, busy, overflow, level);
endinterface

// File: rtl/byte_uart_tx.sv
// byte_uart_tx: FIFO-buffered 8N1 UART transmitter with serializer flow control
module byte_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW = 4
) (
  input logic clk,
  input logic reset,
  byte_uart_tx_if.slave u
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] THRESH = (FIFO_AW+1)'(FIFO_DEPTH - 2);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shift, shift_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] level;
  logic tx_q, tx_n, ovf, push, pop, empty, done;
  assign empty = level == '0;
  assign done = timer == '0;
  // a full FIFO drops the byte even when a pop frees a slot this cycle
  assign push = u.din_valid && level != FULL;
  assign u.tx = tx_q;
  assign u.busy = !empty || state != IDLE;
  assign u.overflow = ovf;
  assign u.level = level;
  assign u.can_accept = level <= THRESH;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= u.din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= RELOAD;
      bit_idx <= '0;
      shift <= '0;
      tx_q <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      bit_idx <= bit_n;
      shift <= shift_n;
      tx_q <= tx_n;
      wr_ptr <= wr_ptr + FIFO_AW'(push);
      rd_ptr <= rd_ptr + FIFO_AW'(pop);
      level <= level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      ovf <= ovf || (u.din_valid && level == FULL);
    end
  end
  always_comb begin
    state_n = state;
    timer_n = timer - TW'(1);
    bit_n = bit_idx;
    shift_n = shift;
    pop = 1'b0;
    case (state)
      IDLE: begin
        timer_n = RELOAD;
        if (!empty) begin
          pop = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
        end
      end
      START: if (done) begin
        timer_n = RELOAD;
        bit_n = '0;
        state_n = DATA;
      end
      DATA: if (done) begin
        timer_n = RELOAD;
        if (bit_idx == 3'd7) state_n = STOP;
        else begin
          shift_n = shift >> 1;
          bit_n = bit_idx + 3'd1;
        end
      end
      STOP: if (done) begin
        timer_n = RELOAD;
        pop = !empty;
        shift_n = empty ? shift : mem[rd_ptr];
        state_n = empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
    // tx is registered from the next state so the line changes with the state
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  end
endmodule

// File: tb/tb_byte_uart_tx.sv
// tb_byte_uart_tx: directed checks of framing, queuing, overflow, flow control and reset
module tb_byte_uart_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic txs[$];
  logic bsy[$];
  logic ovf[$];
  logic cas[$];
  int lev[$];
  logic [7:0] rx[$];
  int starts[$];
  byte_uart_tx_if #(.FIFO_AW(2)) u();
  byte_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (.clk(clk), .reset(reset), .u(u));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_cycle(input logic v, input logic [7:0] d);
    u.din_valid = v;
    u.din = d;
    @(negedge clk);
    txs.push_back(u.tx);
    bsy.push_back(u.busy);
    ovf.push_back(u.overflow);
    cas.push_back(u.can_accept);
    lev.push_back(int'(u.level));
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) run_cycle(1'b0, 8'h00);
  endtask
  task automatic clear_log();
    txs.delete(); bsy.delete(); ovf.delete(); cas.delete(); lev.delete();
  endtask
  task automatic do_reset();
    u.din_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_log();
  endtask
  task automatic decode();
    int i;
    logic [7:0] b;
    rx.delete();
    starts.delete();
    i = 0;
    while (i + 39 < txs.size()) begin
      if (txs[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = txs[i + 4 * k + 5];
        rx.push_back(b);
        starts.push_back(i);
        chk("stop_bit", int'(txs[i + 38]), 1);
        i += 40;
      end else i++;
    end
  endtask
  initial begin
    logic [7:0] pat;
    logic pend;
    int sent, viol, saw3, e;
    u.din_valid = 1'b0;
    u.din = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", int'(u.tx), 1);
    chk("rst_busy", int'(u.busy), 0);
    chk("rst_ovf", int'(u.overflow), 0);
    chk("rst_level", int'(u.level), 0);
    chk("rst_can_accept", int'(u.can_accept), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_log();
    // single byte 0xA5, exact waveform
    pat = 8'hA5;
    run_cycle(1'b1, pat);
    idle(45);
    for (int c = 0; c < 46; c++) begin
      e = c < 2 ? 1 : c < 6 ? 0 : c < 38 ? int'(pat[(c - 6) / 4]) : 1;
      chk($sformatf("a5_tx_c%0d", c), int'(txs[c]), e);
    end
    chk("a5_busy_41", int'(bsy[41]), 1);
    chk("a5_busy_42", int'(bsy[42]), 0);
    chk("a5_ovf", int'(ovf[45]), 0);
    // three back-to-back frames
    do_reset();
    run_cycle(1'b1, 8'h01);
    run_cycle(1'b1, 8'h02);
    run_cycle(1'b1, 8'h03);
    idle(125);
    decode();
    chk("b2b_count", rx.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b_byte%0d", k), k < rx.size() ? int'(rx[k]) : -1, k + 1);
      chk($sformatf("b2b_start%0d", k), k < starts.size() ? starts[k] : -1, 2 + 40 * k);
    end
    chk("b2b_no_gap", int'(txs[42]), 0);
    chk("b2b_busy_121", int'(bsy[121]), 1);
    chk("b2b_busy_122", int'(bsy[122]), 0);
    // six strobes into a 4-deep FIFO
    do_reset();
    for (int k = 0; k < 6; k++) run_cycle(1'b1, 8'h10 + 8'(k));
    idle(210);
    chk("ovf_c5", int'(ovf[5]), 0);
    chk("ovf_c6", int'(ovf[6]), 1);
    chk("ovf_level_c6", lev[6], 4);
    chk("ovf_sticky", int'(ovf[215]), 1);
    decode();
    chk("ovf_count", rx.size(), 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("ovf_byte%0d", k), k < rx.size() ? int'(rx[k]) : -1, 'h10 + k);
    // serializer driven by can_accept as shift_enable
    do_reset();
    pend = 1'b0;
    sent = 0;
    viol = 0;
    saw3 = 0;
    for (int c = 0; c < 880; c++) begin
      run_cycle(pend, pend ? 8'h30 + 8'(sent) : 8'h00);
      if (pend) sent++;
      if (cas[c] != (lev[c] <= 2)) viol++;
      if (lev[c] == 3) saw3 = 1;
      pend = cas[c] && (sent + (pend ? 0 : 0)) < 20;
    end
    chk("fc_sent", sent, 20);
    chk("fc_ca_rule", viol, 0);
    chk("fc_level3_seen", saw3, 1);
    chk("fc_ovf", int'(ovf[879]), 0);
    decode();
    chk("fc_count", rx.size(), 20);
    for (int k = 0; k < 20; k++)
      chk($sformatf("fc_byte%0d", k), k < rx.size() ? int'(rx[k]) : -1, 'h30 + k);
    // reset during DATA bit 3 with two bytes queued
    do_reset();
    run_cycle(1'b1, 8'hC3);
    run_cycle(1'b1, 8'h11);
    run_cycle(1'b1, 8'h22);
    idle(16);
    chk("mid_tx_c18", int'(txs[18]), 0);
    chk("mid_level_c18", lev[18], 2);
    reset = 1'b1;
    run_cycle(1'b0, 8'h00);
    reset = 1'b0;
    run_cycle(1'b0, 8'h00);
    chk("mid_tx", int'(txs[20]), 1);
    chk("mid_level", lev[20], 0);
    chk("mid_busy", int'(bsy[20]), 0);
    chk("mid_ovf", int'(ovf[20]), 0);
    clear_log();
    run_cycle(1'b1, 8'h5A);
    idle(50);
    decode();
    chk("mid_count", rx.size(), 1);
    chk("mid_byte", rx.size() > 0 ? int'(rx[0]) : -1, 'h5A);
    chk("mid_start", starts.size() > 0 ? starts[0] : -1, 2);
    // full FIFO with a pop in the same cycle still drops
    do_reset();
    for (int k = 0; k < 5; k++) run_cycle(1'b1, 8'h60 + 8'(k));
    idle(36);
    run_cycle(1'b1, 8'h77);
    idle(200);
    chk("full_level_c41", lev[41], 4);
    chk("full_level_c42", lev[42], 3);
    chk("full_ovf_c41", int'(ovf[41]), 0);
    chk("full_ovf_c42", int'(ovf[42]), 1);
    decode();
    chk("full_count", rx.size(), 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("full_byte%0d", k), k < rx.size() ? int'(rx[k]) : -1, 'h60 + k);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
